mem_arbiter: RTL

Arbitrates a single shared main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the pipelined processor. It sits between the two caches, whose hit signals drive the pipeline stall/enable inputs, and the line-wide main memory. It serialises one line transaction at a time, with round-robin priority on simultaneous requests. It holds requesters via a req/ack handshake until their line transfer completes.

---
 rtl/proc_pkg.sv | 8 +
 rtl/mem_arbiter_rr2.sv | 32 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor types and cache line constants
package proc_pkg;
  localparam int LINE_W = 128;
  localparam int OFF_W  = 4;

  typedef enum logic [1:0] {IDLE, MEM, RESP} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/mem_arbiter_rr2.sv
// rtl/mem_arbiter_rr2.sv - two-way round-robin picker with last-grant memory
module arb_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic ireq,
  input  logic dreq,
  input  logic update,
  input  logic servedD,
  output logic pickD
);
  import proc_pkg::*;

  grant_t lastGrant;

  // Only completed transactions move the pointer; an abandoned one leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= GNT_I;
    end else if (update) begin
      lastGrant <= servedD ? GNT_D : GNT_I;
    end
  end

  always_comb begin
    pickD = 1'b0;
    if (ireq && dreq) begin
      pickD = (lastGrant == GNT_I);
    end else begin
      pickD = dreq;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises icache/dcache line transactions onto one memory port
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = proc_pkg::LINE_W,
  parameter int OFF_W  = proc_pkg::OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iack,
  output logic [LINE_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [LINE_W-1:0] dwdata,
  output logic              dack,
  output logic [LINE_W-1:0] drdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  import proc_pkg::*;

  arb_state_t        state;
  arb_state_t        nextState;
  grant_t            grant;
  logic              pickD;
  logic              lineDone;
  logic              accept;
  logic [ADDR_W-1:0] selAddr;
  logic [LINE_W-1:0] lineBuf;

  assign lineDone = (state == MEM) && mem_ready;
  assign accept   = (state == IDLE) && (ireq || dreq);
  assign selAddr  = pickD ? daddr : iaddr;

  arb_rr2 uRr (
    .clk     (clk),
    .reset   (reset),
    .ireq    (ireq),
    .dreq    (dreq),
    .update  (lineDone),
    .servedD (grant == GNT_D),
    .pickD   (pickD)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (ireq || dreq) nextState = MEM;
      MEM:     if (mem_ready) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Command is captured once at grant so requester changes during MEM/RESP are invisible.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= GNT_I;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lineBuf   <= '0;
    end else begin
      if (accept) begin
        grant     <= pickD ? GNT_D : GNT_I;
        mem_we    <= pickD & dwe;
        mem_addr  <= {selAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_wdata <= dwdata;
      end
      if (lineDone) begin
        lineBuf <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_req = (state == MEM);
    iack    = (state == RESP) && (grant == GNT_I);
    dack    = (state == RESP) && (grant == GNT_D);
  end

  assign irdata = lineBuf;
  assign drdata = lineBuf;
endmodule
